// File: rtl/ldm_stm_addr_sequencer.sv
// rtl/ldm_stm_addr_sequencer.sv - turns the LDM/STM register-address stream into registered memory transfers
// Optional feature macro: LDM_STM_PC_LOAD_EN (adds pc_load_out for loads into R15).
module ldm_stm_addr_sequencer #(
  parameter int ADDR_W = 32,
  parameter int STEP   = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic [15:0]       reg_list_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic              p_bit_in,
  input  logic              u_bit_in,
  input  logic              w_bit_in,
  input  logic              l_bit_in,
  input  logic              reg_en_in,
  input  logic [3:0]        reg_addr_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_rd_en_out,
  output logic              mem_wr_en_out,
  output logic [3:0]        rf_addr_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              wb_en_out,
`ifdef LDM_STM_PC_LOAD_EN
  output logic              pc_load_out,
`endif
  output logic [ADDR_W-1:0] wb_data_out
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, wb_val_q, wb_val_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, wb_data_q, wb_data_d;
  logic              l_q, l_d, wb_flag_q, wb_flag_d;
  logic              rd_q, rd_d, wr_q, wr_d, done_q, done_d, wb_en_q, wb_en_d;
  logic [3:0]        rf_q, rf_d;
`ifdef LDM_STM_PC_LOAD_EN
  logic              pc_q, pc_d;
`endif

  logic [4:0]        n_regs;
  logic [ADDR_W-1:0] span, s_addr, wb_calc;
  logic [ADDR_W-1:0] cur_ptr, cur_val;
  logic              cur_l, cur_flag;

  always_comb begin
    n_regs = '0;
    for (int i = 0; i < 16; i++) n_regs = n_regs + {4'd0, reg_list_in[i]};
  end

  assign span    = STEP_W * ADDR_W'(n_regs);
  assign wb_calc = u_bit_in ? base_addr_in + span : base_addr_in - span;

  // Lowest register always lands at the lowest address, so decrement modes start below base.
  always_comb begin
    case ({p_bit_in, u_bit_in})
      2'b01:   s_addr = base_addr_in;
      2'b11:   s_addr = base_addr_in + STEP_W;
      2'b00:   s_addr = base_addr_in - span + STEP_W;
      default: s_addr = base_addr_in - span;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    l_d        = l_q;
    wb_flag_d  = wb_flag_q;
    wb_val_d   = wb_val_q;
    mem_addr_d = mem_addr_q;
    rf_d       = rf_q;
    wb_data_d  = wb_data_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    done_d     = 1'b0;
    wb_en_d    = 1'b0;
`ifdef LDM_STM_PC_LOAD_EN
    pc_d       = 1'b0;
`endif
    cur_ptr    = ptr_q;
    cur_l      = l_q;
    cur_flag   = wb_flag_q;
    cur_val    = wb_val_q;

    // A start (even while busy) reloads everything and is itself the first transfer cycle.
    if (start_in) begin
      cur_ptr   = s_addr;
      cur_l     = l_bit_in;
      cur_flag  = w_bit_in && (n_regs != 5'd0);
      cur_val   = wb_calc;
      l_d       = cur_l;
      wb_flag_d = cur_flag;
      wb_val_d  = cur_val;
    end

    if (start_in || state_q == XFER) begin
      if (reg_en_in) begin
        rd_d       = cur_l;
        wr_d       = !cur_l;
        mem_addr_d = cur_ptr;
        rf_d       = reg_addr_in;
        ptr_d      = cur_ptr + STEP_W;
        state_d    = XFER;
`ifdef LDM_STM_PC_LOAD_EN
        pc_d       = cur_l && (reg_addr_in == 4'd15);
`endif
      end else begin
        done_d    = 1'b1;
        wb_en_d   = cur_flag;
        wb_data_d = cur_val;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      l_q        <= 1'b0;
      wb_flag_q  <= 1'b0;
      wb_val_q   <= '0;
      mem_addr_q <= '0;
      rf_q       <= '0;
      wb_data_q  <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      wb_en_q    <= 1'b0;
`ifdef LDM_STM_PC_LOAD_EN
      pc_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      l_q        <= l_d;
      wb_flag_q  <= wb_flag_d;
      wb_val_q   <= wb_val_d;
      mem_addr_q <= mem_addr_d;
      rf_q       <= rf_d;
      wb_data_q  <= wb_data_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      wb_en_q    <= wb_en_d;
`ifdef LDM_STM_PC_LOAD_EN
      pc_q       <= pc_d;
`endif
    end
  end

  assign mem_addr_out  = mem_addr_q;
  assign mem_rd_en_out = rd_q;
  assign mem_wr_en_out = wr_q;
  assign rf_addr_out   = rf_q;
  // Busy stays up through the done cycle.
  assign busy_out      = (state_q == XFER) || done_q;
  assign done_out      = done_q;
  assign wb_en_out     = wb_en_q;
  assign wb_data_out   = wb_data_q;
`ifdef LDM_STM_PC_LOAD_EN
  assign pc_load_out   = pc_q;
`endif

endmodule

// File: tb/tb_ldm_stm_addr_sequencer.sv
// tb/tb_ldm_stm_addr_sequencer.sv - directed self-checking bench for ldm_stm_addr_sequencer
module tb_ldm_stm_addr_sequencer;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        start_in = 1'b0;
  logic [15:0] reg_list_in = '0;
  logic [31:0] base_addr_in = '0;
  logic        p_bit_in = 1'b0, u_bit_in = 1'b0, w_bit_in = 1'b0, l_bit_in = 1'b0;
  logic        reg_en_in = 1'b0;
  logic [3:0]  reg_addr_in = '0;
  logic [31:0] mem_addr_out, wb_data_out;
  logic        mem_rd_en_out, mem_wr_en_out, busy_out, done_out, wb_en_out;
  logic [3:0]  rf_addr_out;
`ifdef LDM_STM_PC_LOAD_EN
  logic        pc_load_out;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ldm_stm_addr_sequencer dut (
    .clk_in       (clk),
    .reset_in     (reset_in),
    .start_in     (start_in),
    .reg_list_in  (reg_list_in),
    .base_addr_in (base_addr_in),
    .p_bit_in     (p_bit_in),
    .u_bit_in     (u_bit_in),
    .w_bit_in     (w_bit_in),
    .l_bit_in     (l_bit_in),
    .reg_en_in    (reg_en_in),
    .reg_addr_in  (reg_addr_in),
    .mem_addr_out (mem_addr_out),
    .mem_rd_en_out(mem_rd_en_out),
    .mem_wr_en_out(mem_wr_en_out),
    .rf_addr_out  (rf_addr_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .wb_en_out    (wb_en_out),
`ifdef LDM_STM_PC_LOAD_EN
    .pc_load_out  (pc_load_out),
`endif
    .wb_data_out  (wb_data_out)
  );

  task automatic setup(input logic [15:0] list, input logic [31:0] base,
                       input logic p, input logic u, input logic w, input logic l);
    reg_list_in = list; base_addr_in = base;
    p_bit_in = p; u_bit_in = u; w_bit_in = w; l_bit_in = l;
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic st, input logic en, input logic [3:0] ra);
    start_in = st; reg_en_in = en; reg_addr_in = ra;
    @(posedge clk); #1;
    start_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    vectors++;
    if ({mem_addr_out, mem_rd_en_out, mem_wr_en_out, rf_addr_out, busy_out, done_out,
         wb_en_out, wb_data_out} !== '0) begin
      errors++;
      $display("FAIL reset: addr=%h rd=%b wr=%b rf=%h busy=%b done=%b wb_en=%b wb=%h, required all zero",
               mem_addr_out, mem_rd_en_out, mem_wr_en_out, rf_addr_out, busy_out, done_out, wb_en_out, wb_data_out);
    end
    reset_in = 1'b0;
  endtask

  task automatic test_ldmia();
    logic [31:0] ea [3] = '{32'h100, 32'h104, 32'h108};
    logic [3:0]  er [3] = '{4'd0, 4'd2, 4'd4};
    setup(16'h0015, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(i == 0, 1'b1, er[i]);
      vectors++;
      if ({mem_rd_en_out, mem_wr_en_out, mem_addr_out, rf_addr_out, busy_out, done_out} !==
          {1'b1, 1'b0, ea[i], er[i], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL ldmia_xfer%0d: rd=%b wr=%b addr=%h rf=%h busy=%b done=%b, required rd=1 addr=%h rf=%h busy=1",
                 i, mem_rd_en_out, mem_wr_en_out, mem_addr_out, rf_addr_out, busy_out, done_out, ea[i], er[i]);
      end
    end
    step(1'b0, 1'b0, 4'd0);
    vectors++;
    if ({done_out, wb_en_out, wb_data_out, mem_rd_en_out, mem_wr_en_out, busy_out} !==
        {1'b1, 1'b1, 32'h10C, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ldmia_done: done=%b wb_en=%b wb=%h rd=%b wr=%b busy=%b, required done=1 wb_en=1 wb=0000010c busy=1",
               done_out, wb_en_out, wb_data_out, mem_rd_en_out, mem_wr_en_out, busy_out);
    end
    step(1'b0, 1'b0, 4'd0);
    vectors++;
    if ({done_out, wb_en_out, busy_out} !== 3'b000) begin
      errors++;
      $display("FAIL ldmia_idle: done=%b wb_en=%b busy=%b, required 0 0 0", done_out, wb_en_out, busy_out);
    end
  endtask

  task automatic test_stmdb();
    logic [31:0] ea [4] = '{32'h1F0, 32'h1F4, 32'h1F8, 32'h1FC};
    logic [3:0]  er [4] = '{4'd0, 4'd1, 4'd14, 4'd15};
    setup(16'hC003, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 1'b1, er[i]);
      vectors++;
      if ({mem_rd_en_out, mem_wr_en_out, mem_addr_out, rf_addr_out, done_out} !==
          {1'b0, 1'b1, ea[i], er[i], 1'b0}) begin
        errors++;
        $display("FAIL stmdb_xfer%0d: rd=%b wr=%b addr=%h rf=%h done=%b, required wr=1 addr=%h rf=%h",
                 i, mem_rd_en_out, mem_wr_en_out, mem_addr_out, rf_addr_out, done_out, ea[i], er[i]);
      end
`ifdef LDM_STM_PC_LOAD_EN
      vectors++;
      if (pc_load_out !== 1'b0) begin
        errors++;
        $display("FAIL stmdb_pc%0d: pc_load=%b, required 0", i, pc_load_out);
      end
`endif
    end
    step(1'b0, 1'b0, 4'd0);
    vectors++;
    if ({done_out, wb_en_out, wb_data_out, mem_wr_en_out} !== {1'b1, 1'b1, 32'h1F0, 1'b0}) begin
      errors++;
      $display("FAIL stmdb_done: done=%b wb_en=%b wb=%h wr=%b, required 1 1 000001f0 0",
               done_out, wb_en_out, wb_data_out, mem_wr_en_out);
    end
    step(1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_single();
    // Pass 0: LDMIB -> 0x104 read; pass 1: STMDA -> 0x100 write.
    logic [31:0] ea [2] = '{32'h104, 32'h100};
    for (int k = 0; k < 2; k++) begin
      setup(16'h0001, 32'h100, k == 0, k == 0, 1'b0, k == 0);
      step(1'b1, 1'b1, 4'd0);
      vectors++;
      if ({mem_rd_en_out, mem_wr_en_out, mem_addr_out, rf_addr_out} !==
          {k == 0, k == 1, ea[k], 4'd0}) begin
        errors++;
        $display("FAIL single%0d_xfer: rd=%b wr=%b addr=%h rf=%h, required rd=%0d wr=%0d addr=%h rf=0",
                 k, mem_rd_en_out, mem_wr_en_out, mem_addr_out, rf_addr_out, k == 0, k == 1, ea[k]);
      end
      step(1'b0, 1'b0, 4'd0);
      vectors++;
      if ({done_out, wb_en_out, mem_rd_en_out, mem_wr_en_out} !== 4'b1000) begin
        errors++;
        $display("FAIL single%0d_done: done=%b wb_en=%b rd=%b wr=%b, required 1 0 0 0",
                 k, done_out, wb_en_out, mem_rd_en_out, mem_wr_en_out);
      end
      step(1'b0, 1'b0, 4'd0);
    end
  endtask

  task automatic test_empty();
    setup(16'h0000, 32'h300, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'd0);
    vectors++;
    if ({done_out, wb_en_out, mem_rd_en_out, mem_wr_en_out} !== 4'b1000) begin
      errors++;
      $display("FAIL empty_done: done=%b wb_en=%b rd=%b wr=%b, required 1 0 0 0",
               done_out, wb_en_out, mem_rd_en_out, mem_wr_en_out);
    end
    step(1'b0, 1'b0, 4'd0);
    vectors++;
    if ({done_out, busy_out} !== 2'b00) begin
      errors++;
      $display("FAIL empty_idle: done=%b busy=%b, required 0 0", done_out, busy_out);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea [2] = '{32'hFFFF_FFFC, 32'h0000_0000};
    setup(16'h0003, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(i == 0, 1'b1, 4'(i));
      vectors++;
      if ({mem_rd_en_out, mem_addr_out, rf_addr_out} !== {1'b1, ea[i], 4'(i)}) begin
        errors++;
        $display("FAIL wrap_xfer%0d: rd=%b addr=%h rf=%h, required rd=1 addr=%h rf=%0d",
                 i, mem_rd_en_out, mem_addr_out, rf_addr_out, ea[i], i);
      end
    end
    step(1'b0, 1'b0, 4'd0);
    vectors++;
    if ({done_out, wb_en_out, wb_data_out} !== {1'b1, 1'b1, 32'h0000_0004}) begin
      errors++;
      $display("FAIL wrap_done: done=%b wb_en=%b wb=%h, required 1 1 00000004", done_out, wb_en_out, wb_data_out);
    end
    step(1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_reset_mid();
    setup(16'h00FF, 32'h300, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 4'd0);
    step(1'b0, 1'b1, 4'd1);
    reset_in = 1'b1;
    step(1'b0, 1'b1, 4'd2);
    reset_in = 1'b0;
    vectors++;
    if ({mem_addr_out, mem_rd_en_out, mem_wr_en_out, rf_addr_out, busy_out, done_out,
         wb_en_out, wb_data_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid: addr=%h rd=%b rf=%h busy=%b done=%b wb_en=%b, required all zero",
               mem_addr_out, mem_rd_en_out, rf_addr_out, busy_out, done_out, wb_en_out);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'd0);
      vectors++;
      if ({done_out, wb_en_out, busy_out} !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid_nodone%0d: done=%b wb_en=%b busy=%b, required 0 0 0",
                 i, done_out, wb_en_out, busy_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    setup(16'h00FF, 32'h400, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 4'd0);
    step(1'b0, 1'b1, 4'd1);
    vectors++;
    if ({mem_rd_en_out, mem_addr_out, rf_addr_out} !== {1'b1, 32'h404, 4'd1}) begin
      errors++;
      $display("FAIL restart_prev: rd=%b addr=%h rf=%h, required 1 00000404 1", mem_rd_en_out, mem_addr_out, rf_addr_out);
    end
    setup(16'h0003, 32'h800, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'd0);
    vectors++;
    if ({mem_rd_en_out, mem_wr_en_out, mem_addr_out, rf_addr_out, done_out} !==
        {1'b0, 1'b1, 32'h800, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL restart_new0: rd=%b wr=%b addr=%h rf=%h done=%b, required wr=1 addr=00000800 rf=0 done=0",
               mem_rd_en_out, mem_wr_en_out, mem_addr_out, rf_addr_out, done_out);
    end
    step(1'b0, 1'b1, 4'd1);
    vectors++;
    if ({mem_wr_en_out, mem_addr_out, rf_addr_out, done_out} !== {1'b1, 32'h804, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL restart_new1: wr=%b addr=%h rf=%h done=%b, required 1 00000804 1 0",
               mem_wr_en_out, mem_addr_out, rf_addr_out, done_out);
    end
    step(1'b0, 1'b0, 4'd0);
    vectors++;
    if ({done_out, wb_en_out, wb_data_out} !== {1'b1, 1'b1, 32'h808}) begin
      errors++;
      $display("FAIL restart_done: done=%b wb_en=%b wb=%h, required 1 1 00000808", done_out, wb_en_out, wb_data_out);
    end
    step(1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_idle_ignore();
    step(1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b1, 4'd6);
    vectors++;
    if ({mem_rd_en_out, mem_wr_en_out, busy_out, done_out} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_ignore: rd=%b wr=%b busy=%b done=%b, required 0 0 0 0",
               mem_rd_en_out, mem_wr_en_out, busy_out, done_out);
    end
  endtask

  task automatic test_pc_load();
    logic [3:0] er [2] = '{4'd0, 4'd15};
    setup(16'h8001, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(i == 0, 1'b1, er[i]);
      vectors++;
      if ({mem_rd_en_out, mem_addr_out, rf_addr_out} !== {1'b1, 32'(4 * i), er[i]}) begin
        errors++;
        $display("FAIL pcld_xfer%0d: rd=%b addr=%h rf=%h, required rd=1 addr=%h rf=%h",
                 i, mem_rd_en_out, mem_addr_out, rf_addr_out, 32'(4 * i), er[i]);
      end
`ifdef LDM_STM_PC_LOAD_EN
      vectors++;
      if (pc_load_out !== (i == 1)) begin
        errors++;
        $display("FAIL pcld_pc%0d: pc_load=%b, required %0d", i, pc_load_out, i == 1);
      end
`endif
    end
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_ldmia();
    test_stmdb();
    test_single();
    test_empty();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_idle_ignore();
    test_pc_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
